// File: rtl/tictactoe_pkg.sv
// Shared tic-tac-toe definitions: cell and error codes, the winning-line table
// and the move-writer state encoding.
package tictactoe_pkg;

  localparam logic [1:0] CELL_EMPTY = 2'b00;
  localparam logic [1:0] CELL_P1    = 2'b01;
  localparam logic [1:0] CELL_P2    = 2'b10;

  localparam logic [1:0] ERR_OK    = 2'b00;
  localparam logic [1:0] ERR_RANGE = 2'b01;
  localparam logic [1:0] ERR_OCC   = 2'b10;
  localparam logic [1:0] ERR_TURN  = 2'b11;

  // LINE_TBL[line][k] is the k-th cell of a line; line 0 sits in the low bits
  localparam logic [7:0][2:0][3:0] LINE_TBL = {
    {4'd6, 4'd4, 4'd2},   // 7: anti-diagonal
    {4'd8, 4'd4, 4'd0},   // 6: diagonal
    {4'd8, 4'd5, 4'd2},   // 5: col 2
    {4'd7, 4'd4, 4'd1},   // 4: col 1
    {4'd6, 4'd3, 4'd0},   // 3: col 0
    {4'd8, 4'd7, 4'd6},   // 2: row 2
    {4'd5, 4'd4, 4'd3},   // 1: row 1
    {4'd2, 4'd1, 4'd0}    // 0: row 0
  };

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_SCAN = 2'b01,
    ST_OVER = 2'b10
  } state_t;

  // Cell lookup that tolerates out-of-range indices (returns empty)
  function automatic logic [1:0] cell_at(input logic [8:0][1:0] b, input logic [3:0] idx);
    cell_at = CELL_EMPTY;
    for (int i = 0; i < 9; i++)
      if (idx == 4'(i)) cell_at = b[i];
  endfunction

endpackage

// File: rtl/winner_detect_3.sv
// Three-cell line checker: flags a win when all three cells match and are occupied.
module winner_detect_3
  import tictactoe_pkg::*;
(
  input  logic [1:0] pos0,
  input  logic [1:0] pos1,
  input  logic [1:0] pos2,
  output logic       winner,
  output logic [1:0] who
);

  assign winner = (pos0 != CELL_EMPTY) && (pos0 == pos1) && (pos1 == pos2);
  assign who    = winner ? pos0 : CELL_EMPTY;

endmodule

// File: rtl/board_move_writer.sv
// Board write side: validates moves, writes the board, then scans the eight
// winning lines one per cycle and reports win / draw / error.
module board_move_writer
  import tictactoe_pkg::*;
#(
  parameter logic [1:0] FIRST_PLAYER = CELL_P1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        new_game,
  input  logic        move_valid,
  output logic        move_ready,
  input  logic [3:0]  move_cell,
  input  logic [1:0]  move_player,
  output logic        move_done,
  output logic [1:0]  move_err,
  output logic [17:0] board,
  output logic [1:0]  turn,
  output logic        game_over,
  output logic        winner_valid,
  output logic [1:0]  who
);

  state_t           state_q;
  logic [8:0][1:0]  board_q;
  logic [1:0]       turn_q;
  logic [2:0]       line_idx_q;
  logic             done_q, over_q, wv_q;
  logic [1:0]       err_q, who_q;
  logic             win_q;
  logic [1:0]       win_who_q;

  logic [1:0]       chk_err;
  logic [8:0][1:0]  wr_board;
  logic             full;
  logic [2:0][3:0]  line_cells;
  logic             det_win;
  logic [1:0]       det_who;
  logic             fin_win;
  logic [1:0]       fin_who;

  // Validation priority: range, then turn, then occupancy
  always_comb begin
    chk_err = ERR_OK;
    if (move_cell > 4'd8)
      chk_err = ERR_RANGE;
    else if (move_player != turn_q)
      chk_err = ERR_TURN;
    else if (cell_at(board_q, move_cell) != CELL_EMPTY)
      chk_err = ERR_OCC;
  end

  always_comb begin
    wr_board = board_q;
    for (int i = 0; i < 9; i++)
      if (move_cell == 4'(i)) wr_board[i] = move_player;
  end

  always_comb begin
    full = 1'b1;
    for (int i = 0; i < 9; i++)
      if (board_q[i] == CELL_EMPTY) full = 1'b0;
  end

  assign line_cells = LINE_TBL[line_idx_q];

  winner_detect_3 u_line (
    .pos0   (cell_at(board_q, line_cells[0])),
    .pos1   (cell_at(board_q, line_cells[1])),
    .pos2   (cell_at(board_q, line_cells[2])),
    .winner (det_win),
    .who    (det_who)
  );

  // The last line is folded in directly so completion lands in cycle 9
  assign fin_win = win_q | det_win;
  assign fin_who = win_q ? win_who_q : det_who;

  always_ff @(posedge clk) begin
    if (rst || new_game) begin
      state_q    <= ST_IDLE;
      board_q    <= '0;
      turn_q     <= FIRST_PLAYER;
      line_idx_q <= '0;
      done_q     <= 1'b0;
      err_q      <= ERR_OK;
      over_q     <= 1'b0;
      wv_q       <= 1'b0;
      who_q      <= CELL_EMPTY;
      win_q      <= 1'b0;
      win_who_q  <= CELL_EMPTY;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (move_valid) begin
            if (chk_err != ERR_OK) begin
              done_q <= 1'b1;
              err_q  <= chk_err;
            end else begin
              board_q    <= wr_board;
              turn_q     <= (turn_q == CELL_P1) ? CELL_P2 : CELL_P1;
              line_idx_q <= '0;
              win_q      <= 1'b0;
              win_who_q  <= CELL_EMPTY;
              state_q    <= ST_SCAN;
            end
          end
        end
        ST_SCAN: begin
          if (!win_q && det_win) begin
            win_q     <= 1'b1;
            win_who_q <= det_who;
          end
          line_idx_q <= line_idx_q + 3'd1;
          if (line_idx_q == 3'd7) begin
            done_q     <= 1'b1;
            err_q      <= ERR_OK;
            line_idx_q <= '0;
            if (fin_win) begin
              over_q  <= 1'b1;
              wv_q    <= 1'b1;
              who_q   <= fin_who;
              turn_q  <= CELL_EMPTY;
              state_q <= ST_OVER;
            end else if (full) begin
              over_q  <= 1'b1;
              wv_q    <= 1'b0;
              who_q   <= CELL_EMPTY;
              turn_q  <= CELL_EMPTY;
              state_q <= ST_OVER;
            end else begin
              state_q <= ST_IDLE;
            end
          end
        end
        ST_OVER: ;
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign move_ready   = (state_q == ST_IDLE);
  assign move_done    = done_q;
  assign move_err     = err_q;
  assign board        = board_q;
  assign turn         = turn_q;
  assign game_over    = over_q;
  assign winner_valid = wv_q;
  assign who          = who_q;

endmodule

// File: tb/tb_board_move_writer.sv
// Directed + random moves against a plain array model of the game.
module tb_board_move_writer;

  logic        clk = 1'b0;
  logic        rst, new_game, move_valid;
  logic [3:0]  move_cell;
  logic [1:0]  move_player;
  logic        move_ready, move_done, game_over, winner_valid;
  logic [1:0]  move_err, turn, who;
  logic [17:0] board;

  int n_chk = 0;
  int n_fail = 0;

  logic [1:0] mb [9];
  logic [1:0] mturn;
  bit         mover;
  logic [1:0] mwho;
  bit         mwv;

  board_move_writer #(.FIRST_PLAYER(2'b01)) dut (
    .clk(clk), .rst(rst), .new_game(new_game),
    .move_valid(move_valid), .move_ready(move_ready),
    .move_cell(move_cell), .move_player(move_player),
    .move_done(move_done), .move_err(move_err),
    .board(board), .turn(turn), .game_over(game_over),
    .winner_valid(winner_valid), .who(who)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [17:0] mpack();
    logic [17:0] b = '0;
    for (int i = 0; i < 9; i++) b[2*i +: 2] = mb[i];
    return b;
  endfunction

  function automatic logic [1:0] m3(input int a, input int b, input int c);
    if (mb[a] != 2'b00 && mb[a] == mb[b] && mb[b] == mb[c]) return mb[a];
    return 2'b00;
  endfunction

  // Rows, columns, then both diagonals
  function automatic logic [1:0] mwinner();
    for (int r = 0; r < 3; r++) if (m3(3*r, 3*r+1, 3*r+2) != 2'b00) return m3(3*r, 3*r+1, 3*r+2);
    for (int c = 0; c < 3; c++) if (m3(c, c+3, c+6) != 2'b00) return m3(c, c+3, c+6);
    if (m3(0, 4, 8) != 2'b00) return m3(0, 4, 8);
    return m3(2, 4, 6);
  endfunction

  function automatic bit mfull();
    for (int i = 0; i < 9; i++) if (mb[i] == 2'b00) return 1'b0;
    return 1'b1;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 9; i++) mb[i] = 2'b00;
    mturn = 2'b01; mover = 1'b0; mwho = 2'b00; mwv = 1'b0;
  endtask

  task automatic check_idle_state(input string tag);
    chk({tag, "_board"}, board, 18'd0);
    chk({tag, "_turn"}, turn, 2'b01);
    chk({tag, "_ready"}, move_ready, 1'b1);
    chk({tag, "_done"}, move_done, 1'b0);
    chk({tag, "_over"}, game_over, 1'b0);
    chk({tag, "_wv"}, winner_valid, 1'b0);
    chk({tag, "_who"}, who, 2'b00);
  endtask

  task automatic do_new_game();
    new_game = 1'b1;
    @(posedge clk); #1;
    new_game = 1'b0;
    model_reset();
    check_idle_state("newgame");
  endtask

  // Issue one move (model must be in IDLE) and check the full result
  task automatic do_move(input logic [3:0] c, input logic [1:0] p);
    logic [1:0] exp_err;
    int lat, exp_lat;
    if (c > 8) exp_err = 2'b01;
    else if (p != mturn) exp_err = 2'b11;
    else if (mb[c] != 2'b00) exp_err = 2'b10;
    else exp_err = 2'b00;
    if (exp_err == 2'b00) begin
      mb[c] = p;
      mturn = (mturn == 2'b01) ? 2'b10 : 2'b01;
      mwho = mwinner();
      if (mwho != 2'b00) begin mover = 1'b1; mwv = 1'b1; mturn = 2'b00; end
      else if (mfull()) begin mover = 1'b1; mturn = 2'b00; end
    end
    exp_lat = (exp_err == 2'b00) ? 9 : 1;
    chk("ready_pre", move_ready, 1'b1);
    move_valid = 1'b1; move_cell = c; move_player = p;
    @(posedge clk); #1;
    move_valid = 1'b0;
    move_cell = 4'($urandom); move_player = 2'($urandom);
    lat = 1;
    if (exp_err == 2'b00) chk("board_cycle1", board, mpack());
    while (!move_done && lat < 20) begin
      chk("ready_scan", move_ready, 1'b0);
      @(posedge clk); #1;
      lat++;
    end
    chk("done_latency", lat, exp_lat);
    chk("err", move_err, exp_err);
    chk("board", board, mpack());
    chk("turn", turn, mturn);
    chk("game_over", game_over, mover);
    chk("winner_valid", winner_valid, mwv);
    chk("who", who, mover ? mwho : 2'b00);
    chk("ready_post", move_ready, !mover);
  endtask

  task automatic over_hold(input int n);
    logic [17:0] snap;
    snap = mpack();
    move_valid = 1'b1;
    for (int i = 0; i < n; i++) begin
      move_cell = 4'($urandom_range(0, 8)); move_player = 2'($urandom_range(1, 2));
      @(posedge clk); #1;
      chk("over_no_done", move_done, 1'b0);
    end
    move_valid = 1'b0;
    chk("over_board", board, snap);
    chk("over_ready", move_ready, 1'b0);
    chk("over_flag", game_over, 1'b1);
  endtask

  initial begin
    rst = 1'b1; new_game = 1'b0; move_valid = 1'b0; move_cell = '0; move_player = '0;
    repeat (3) @(posedge clk);
    #1;
    check_idle_state("reset");
    chk("reset_err", move_err, 2'b00);
    rst = 1'b0;
    model_reset();

    // Single centre move
    do_move(4'd4, 2'b01);

    // P1 wins along row 0
    do_new_game();
    do_move(4'd0, 2'b01); do_move(4'd3, 2'b10); do_move(4'd1, 2'b01);
    do_move(4'd4, 2'b10); do_move(4'd2, 2'b01);
    over_hold(20);

    // Error paths
    do_new_game();
    do_move(4'd9, 2'b01);
    do_move(4'd15, 2'b10);
    do_move(4'd0, 2'b10);
    do_move(4'd0, 2'b00);
    do_move(4'd0, 2'b01);
    do_move(4'd0, 2'b10);
    do_move(4'd4, 2'b11);

    // Draw
    do_new_game();
    do_move(4'd0, 2'b01); do_move(4'd1, 2'b10); do_move(4'd2, 2'b01);
    do_move(4'd4, 2'b10); do_move(4'd3, 2'b01); do_move(4'd5, 2'b10);
    do_move(4'd7, 2'b01); do_move(4'd6, 2'b10); do_move(4'd8, 2'b01);
    chk("draw_who", who, 2'b00);

    // Ninth move that also completes column 0 is a win
    do_new_game();
    do_move(4'd0, 2'b01); do_move(4'd1, 2'b10); do_move(4'd2, 2'b01);
    do_move(4'd4, 2'b10); do_move(4'd3, 2'b01); do_move(4'd5, 2'b10);
    do_move(4'd7, 2'b01); do_move(4'd8, 2'b10); do_move(4'd6, 2'b01);
    chk("fullwin_wv", winner_valid, 1'b1);

    // new_game beats a simultaneous move
    do_new_game();
    do_move(4'd0, 2'b01);
    new_game = 1'b1; move_valid = 1'b1; move_cell = 4'd4; move_player = 2'b10;
    @(posedge clk); #1;
    new_game = 1'b0; move_valid = 1'b0;
    model_reset();
    check_idle_state("simul");
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      chk("simul_no_done", move_done, 1'b0);
    end

    // new_game in cycle 4 of a scan
    move_valid = 1'b1; move_cell = 4'd4; move_player = 2'b01;
    @(posedge clk); #1;
    move_valid = 1'b0;
    chk("midscan_busy", move_ready, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    new_game = 1'b1;
    @(posedge clk); #1;
    new_game = 1'b0;
    model_reset();
    check_idle_state("midscan");
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      chk("midscan_no_done", move_done, 1'b0);
    end

    // Random games
    for (int g = 0; g < 8; g++) begin
      do_new_game();
      for (int m = 0; m < 60 && !mover; m++) begin
        logic [1:0] p;
        p = ($urandom_range(0, 3) != 0) ? mturn : 2'($urandom_range(0, 3));
        do_move(4'($urandom_range(0, 10)), p);
      end
      if (mover) over_hold(5);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
